// File: rtl/aes_stream_seq_if.sv
// 32-bit AXI4-Stream style link used on both sides of aes_stream_seq.
// The master drives data/valid/last, the slave answers with ready.
interface aes_stream_seq_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/aes_stream_seq.sv
// aes_stream_seq: sequencer between a 32-bit stream pair and an iterative
// AES-128 encrypt core. Collects 4 plaintext words and 4 key words, strobes
// the key, starts the core, waits for done (with watchdog) and streams the
// 4 ciphertext words back out with tlast on the final word.
// Optional feature macro: AES_SEQ_KEY_REUSE_EN -- tlast on the 4th plaintext
// word re-encrypts with the key already held by the core (no key strobe).
module aes_stream_seq #(
    parameter int WORD_W    = 32,
    parameter int BLK_W     = 128,
    parameter int TIMEOUT_W = 8
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    aes_stream_seq_if.slave      s_axis,
    aes_stream_seq_if.master     m_axis,
    output logic [BLK_W-1:0]     aes_plaintext,
    output logic [BLK_W-1:0]     aes_key,
    output logic                 aes_key_strobe,
    output logic                 en,
    input  logic                 aes_done,
    input  logic [BLK_W-1:0]     aes_ciphertext,
    output logic                 err
);

    localparam int NWORDS = BLK_W / WORD_W;

    localparam logic [2:0] LOAD_PT  = 3'd0;
    localparam logic [2:0] LOAD_KEY = 3'd1;
    localparam logic [2:0] START    = 3'd2;
    localparam logic [2:0] WAIT     = 3'd3;
    localparam logic [2:0] SEND     = 3'd4;

    logic [2:0]                    state_q, state_d;
    logic [1:0]                    cnt_q, cnt_d;
    // Word k lives in element (3-k) so word 0 lands in the top 32 bits.
    logic [NWORDS-1:0][WORD_W-1:0] pt_q, pt_d;
    logic [NWORDS-1:0][WORD_W-1:0] key_q, key_d;
    logic [NWORDS-1:0][WORD_W-1:0] ct_q, ct_d;
    logic [TIMEOUT_W-1:0]          wdog_q, wdog_d;
    logic                          tready_q, tready_d;
    logic                          err_q, err_d;
    logic                          s_hs, m_hs, fault;
`ifdef AES_SEQ_KEY_REUSE_EN
    logic                          reuse_q, reuse_d;
    logic                          key_loaded_q, key_loaded_d;
`endif

    assign s_hs = s_axis.tvalid && tready_q;
    assign m_hs = (state_q == SEND) && m_axis.tready;

    // Next-state, word capture and watchdog logic for the frame sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pt_d    = pt_q;
        key_d   = key_q;
        ct_d    = ct_q;
        wdog_d  = wdog_q;
        err_d   = 1'b0;
        fault   = 1'b0;
`ifdef AES_SEQ_KEY_REUSE_EN
        reuse_d      = reuse_q;
        key_loaded_d = key_loaded_q;
`endif
        case (state_q)
            LOAD_PT: begin
                if (s_hs) begin
                    if (s_axis.tlast) begin
`ifdef AES_SEQ_KEY_REUSE_EN
                        if (cnt_q == 2'd3 && key_loaded_q) begin
                            pt_d[~cnt_q] = s_axis.tdata;
                            cnt_d        = 2'd0;
                            reuse_d      = 1'b1;
                            state_d      = START;
                        end else begin
                            fault = 1'b1;
                        end
`else
                        fault = 1'b1;
`endif
                    end else begin
                        pt_d[~cnt_q] = s_axis.tdata;
                        cnt_d        = cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            state_d = LOAD_KEY;
                        end
                    end
                end
            end
            LOAD_KEY: begin
                if (s_hs) begin
                    if (cnt_q == 2'd3) begin
                        if (s_axis.tlast) begin
                            key_d[~cnt_q] = s_axis.tdata;
                            cnt_d         = 2'd0;
                            state_d       = START;
`ifdef AES_SEQ_KEY_REUSE_EN
                            reuse_d       = 1'b0;
`endif
                        end else begin
                            fault = 1'b1;
                        end
                    end else if (s_axis.tlast) begin
                        fault = 1'b1;
                    end else begin
                        key_d[~cnt_q] = s_axis.tdata;
                        cnt_d         = cnt_q + 2'd1;
                    end
                end
            end
            START: begin
                wdog_d  = '0;
                state_d = WAIT;
`ifdef AES_SEQ_KEY_REUSE_EN
                key_loaded_d = 1'b1;
`endif
            end
            WAIT: begin
                wdog_d = wdog_q + TIMEOUT_W'(1);
                if (aes_done) begin
                    ct_d    = aes_ciphertext;
                    cnt_d   = 2'd0;
                    state_d = SEND;
                end else if (wdog_d == '1) begin
                    fault = 1'b1;
                end
            end
            SEND: begin
                if (m_hs) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = LOAD_PT;
                    end
                end
            end
            default: begin
                state_d = LOAD_PT;
                cnt_d   = 2'd0;
            end
        endcase
        // Framing errors and watchdog expiry abandon the frame.
        if (fault) begin
            err_d   = 1'b1;
            cnt_d   = 2'd0;
            state_d = LOAD_PT;
        end
        tready_d = (state_d == LOAD_PT) || (state_d == LOAD_KEY);
    end

    // State registers; reset clears data too so every output reads 0.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q  <= LOAD_PT;
            cnt_q    <= 2'd0;
            pt_q     <= '0;
            key_q    <= '0;
            ct_q     <= '0;
            wdog_q   <= '0;
            tready_q <= 1'b0;
            err_q    <= 1'b0;
`ifdef AES_SEQ_KEY_REUSE_EN
            reuse_q      <= 1'b0;
            key_loaded_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pt_q     <= pt_d;
            key_q    <= key_d;
            ct_q     <= ct_d;
            wdog_q   <= wdog_d;
            tready_q <= tready_d;
            err_q    <= err_d;
`ifdef AES_SEQ_KEY_REUSE_EN
            reuse_q      <= reuse_d;
            key_loaded_q <= key_loaded_d;
`endif
        end
    end

    assign s_axis.tready = tready_q;
    assign m_axis.tvalid = (state_q == SEND);
    assign m_axis.tdata  = (state_q == SEND) ? ct_q[~cnt_q] : '0;
    assign m_axis.tlast  = (state_q == SEND) && (cnt_q == 2'd3);
    assign aes_plaintext = pt_q;
    assign aes_key       = key_q;
    assign en            = (state_q == START);
`ifdef AES_SEQ_KEY_REUSE_EN
    assign aes_key_strobe = (state_q == START) && !reuse_q;
`else
    assign aes_key_strobe = (state_q == START);
`endif
    assign err = err_q;

endmodule
